tile_addr_walker: RTL and testbench
===================================

# tile_addr_walker

Parametrised successor to the operand-A address generator in the matrix multiplier front end. It walks a row-major matrix in tiles of `TILE_ROWS` rows by one bus word and emits one byte address per tile row over a valid/ready stream into the read-address FIFO. Relative to the previous generation it adds:
- configurable address width and row pitch;
- band-major or chunk-major walk order;
- partial final bands;
- a pass repeat count;
- abort;
- bubble-free back-to-back issue.

## Interface
- `ADDR_WIDTH`, 16, address width in bits
- `DIM_WIDTH`, 16, width of dimension and pitch inputs
- `BUS_WIDTH_BYTES`, 32, bytes per bus word (power of 2)
- `DATA_WIDTH_BYTES`, 1, bytes per element (power of 2)
- `TILE_ROWS`, 4, rows per band (power of 2, ≥1)
- `REPEAT_WIDTH`, 4, width of repeat count
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `start_i` in 1 — launch a walk; sampled only in IDLE
- `abort_i` in 1 — terminate the walk immediately
- `mode_i` in 1 — 0 = band-major, 1 = chunk-major; captured at start
- `rows_i` in DIM_WIDTH — matrix rows; captured at start
- `cols_i` in DIM_WIDTH — matrix columns in elements; captured at start
- `pitch_i` in DIM_WIDTH — row pitch in bytes; captured at start
- `base_addr_i` in ADDR_WIDTH — byte address of element (0,0); captured at start
- `repeat_i` in REPEAT_WIDTH — pass count minus one; captured at start
- `addr_o` out ADDR_WIDTH — byte address
- `addr_valid_o` out 1 — `addr_o` valid
- `addr_ready_i` in 1 — consumer accepts
- `tile_last_o` out 1 — marks the last row address of the current tile
- `walk_last_o` out 1 — marks the final address of the final pass
- `busy_o` out 1 — high when not in IDLE
- `done_o` out 1 — one-cycle pulse on normal completion

## Operation
- Derived values:
  - `ELEMENTS = BUS_WIDTH_BYTES/DATA_WIDTH_BYTES`
  - `chunks = ceil(cols/ELEMENTS)`
  - `bands = ceil(rows/TILE_ROWS)`
- A band holds `min(TILE_ROWS, rows − band·TILE_ROWS)` rows. Only those rows are emitted, so the last band may be partial.
- Address for (band b, chunk c, row r) is `base + (b·TILE_ROWS + r)·pitch + c·BUS_WIDTH_BYTES`. It is computed modulo 2^ADDR_WIDTH, and wrap-around is silent.
- Implementation uses incremental adders only; no multipliers.
- Walk order within a tile: r ascending.
  - Mode 0: c inner, b outer.
  - Mode 1: b inner, c outer.
- The whole pass is repeated `repeat_i+1` times.
- FSM states:
  - **IDLE**
    - `start_i` with rows=0 or cols=0 → DONE.
    - Otherwise `start_i` captures the inputs, loads the first address and goes to EMIT.
  - **EMIT**
    - `addr_valid_o`=1.
    - A handshake (`valid & ready`) advances the walk.
    - The handshake that carries `walk_last_o` → DONE.
  - **DONE**
    - `done_o`=1 for one cycle, then → IDLE.
- `abort_i` in any state → IDLE on the next edge. `valid` drops and there is no `done_o` pulse. `reset` has priority over `abort_i`.
- `start_i` outside IDLE is ignored.
- Input changes after start have no effect.

## Timing
- Reset values:
  - `addr_o`=0
  - `addr_valid_o`=0
  - `tile_last_o`=0
  - `walk_last_o`=0
  - `busy_o`=0
  - `done_o`=0
  - FSM in IDLE
- All outputs are registered.
- Latency:
  - `start_i` at edge t → first valid at cycle t+1.
  - `done_o` asserts in the cycle after the final handshake.
  - Zero-dimension start → `done_o` at t+1.
- Throughput: one address per cycle while ready is held high. There are no bubbles at tile, band, chunk or pass boundaries.
- While `valid && !ready`, `addr_o`, `tile_last_o` and `walk_last_o` hold stable.
- A new `start_i` is accepted earliest in the cycle after `done_o`, because the FSM is back in IDLE only then.
- `busy_o` is high in EMIT and DONE.

## Structure
- Package `matmul_addr_pkg` holds:
  - `walk_state_e` (IDLE, EMIT, DONE);
  - `walk_mode_e` (BAND_MAJOR, CHUNK_MAJOR);
  - function `ceil_div`.
- Sub-module `tile_walk_counter` is the natural split. It is a nested row/inner/outer/pass counter that produces the carry and last flags. The top level holds the address accumulators (row, chunk and band bases) and the FSM.

## Test plan
Common settings: ELEMENTS=32, TILE_ROWS=4, ADDR_WIDTH=16, ready held high unless noted.

1. **Basic walk:** rows=4, cols=32, pitch=32, base=0x100, mode 0 → addresses 0x100, 0x120, 0x140, 0x160.
   - `tile_last_o` and `walk_last_o` set on the 4th address.
   - `done_o` in the next cycle.
2. **Partial band, mode 0:** rows=6, cols=64, pitch=64, base=0 → 0, 64, 128, 192, 32, 96, 160, 224, 256, 320, 288, 352.
   - `tile_last_o` on the 4th, 8th, 10th and 12th addresses.
3. **Partial band, mode 1:** same inputs as scenario 2, mode 1 → 0, 64, 128, 192, 256, 320, 32, 96, 160, 224, 288, 352.
4. **Backpressure:** scenario 1 with ready low for 3 cycles while the 2nd address is valid → 0x120 held unchanged for 4 cycles, then the sequence completes.
   - No address is lost or duplicated.
5. **Zero dimension:** cols=0 → `done_o` at t+1 and no `valid` asserted.
   - **Abort mid-walk:** abort at the 3rd address → `valid`=0 and `busy_o`=0 next cycle, no `done_o`.
6. **Repeat and wrap:** repeat=1, base=0xFFE0, rows=2, cols=32, pitch=32 → 0xFFE0, 0x0000, 0xFFE0, 0x0000.
   - `walk_last_o` only on the 4th address.

Source files
------------

// File: rtl/matmul_addr_pkg.sv
// Shared types and helpers for the matrix-multiplier operand address walkers.
package matmul_addr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        DONE
    } walk_state_e;

    typedef enum logic {
        BAND_MAJOR,
        CHUNK_MAJOR
    } walk_mode_e;

    // Elaboration-time / constant-divisor ceiling division.
    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/tile_walk_counter.sv
// Nested row / inner / outer / pass position counter for the tile walker.
// The *_last flags are registered and always describe the current position,
// so they double as the carries for the next step.
module tile_walk_counter
    import matmul_addr_pkg::*;
#(
    parameter int DIM_WIDTH    = 16,
    parameter int REPEAT_WIDTH = 4,
    parameter int TILE_ROWS    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic                    step_i,
    input  walk_mode_e              mode_i,
    input  logic [DIM_WIDTH-1:0]    inner_max_i,
    input  logic [DIM_WIDTH-1:0]    outer_max_i,
    input  logic [DIM_WIDTH-1:0]    band_max_i,
    input  logic [DIM_WIDTH-1:0]    last_rows_m1_i,
    input  logic [REPEAT_WIDTH-1:0] repeat_i,
    output logic                    row_last_o,
    output logic                    inner_last_o,
    output logic                    outer_last_o,
    output logic                    walk_last_o
);

    localparam logic [DIM_WIDTH-1:0] FULL_ROWS_M1 = DIM_WIDTH'(TILE_ROWS - 1);

    logic [DIM_WIDTH-1:0]    row_q, row_d, in_q, in_d, out_q, out_d;
    logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
    logic                    row_last_q, in_last_q, out_last_q, pass_last_q, walk_last_q;
    logic [DIM_WIDTH-1:0]    band_idx_d, row_max_d;
    logic                    row_last_d, in_last_d, out_last_d, pass_last_d;

    // Next position: row is the fastest digit, then inner, outer, pass.
    always_comb begin
        row_d  = row_q;
        in_d   = in_q;
        out_d  = out_q;
        pass_d = pass_q;
        if (load_i) begin
            row_d  = '0;
            in_d   = '0;
            out_d  = '0;
            pass_d = '0;
        end else if (step_i) begin
            if (!row_last_q) begin
                row_d = row_q + DIM_WIDTH'(1);
            end else begin
                row_d = '0;
                if (!in_last_q) begin
                    in_d = in_q + DIM_WIDTH'(1);
                end else begin
                    in_d = '0;
                    if (!out_last_q) begin
                        out_d = out_q + DIM_WIDTH'(1);
                    end else begin
                        out_d  = '0;
                        pass_d = pass_q + REPEAT_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Flags of the next position; the final band may hold fewer rows.
    always_comb begin
        band_idx_d  = (mode_i == CHUNK_MAJOR) ? in_d : out_d;
        row_max_d   = (band_idx_d == band_max_i) ? last_rows_m1_i : FULL_ROWS_M1;
        row_last_d  = (row_d == row_max_d);
        in_last_d   = (in_d == inner_max_i);
        out_last_d  = (out_d == outer_max_i);
        pass_last_d = (pass_d == repeat_i);
    end

    // Position and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= '0;
            in_q        <= '0;
            out_q       <= '0;
            pass_q      <= '0;
            row_last_q  <= 1'b0;
            in_last_q   <= 1'b0;
            out_last_q  <= 1'b0;
            pass_last_q <= 1'b0;
            walk_last_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            in_q        <= in_d;
            out_q       <= out_d;
            pass_q      <= pass_d;
            row_last_q  <= row_last_d;
            in_last_q   <= in_last_d;
            out_last_q  <= out_last_d;
            pass_last_q <= pass_last_d;
            walk_last_q <= row_last_d & in_last_d & out_last_d & pass_last_d;
        end
    end

    assign row_last_o   = row_last_q;
    assign inner_last_o = in_last_q;
    assign outer_last_o = out_last_q;
    assign walk_last_o  = walk_last_q;

endmodule

// File: rtl/tile_addr_walker.sv
// Operand tile address walker: emits one byte address per tile row over a
// valid/ready stream, band-major or chunk-major, with repeat and abort.
module tile_addr_walker
    import matmul_addr_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DIM_WIDTH        = 16,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int TILE_ROWS        = 4,
    parameter int REPEAT_WIDTH     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic                    mode_i,
    input  logic [DIM_WIDTH-1:0]    rows_i,
    input  logic [DIM_WIDTH-1:0]    cols_i,
    input  logic [DIM_WIDTH-1:0]    pitch_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [REPEAT_WIDTH-1:0] repeat_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic                    tile_last_o,
    output logic                    walk_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int ELEMENTS = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
    localparam int TR_SHIFT = $clog2(TILE_ROWS);
    localparam logic [DIM_WIDTH-1:0]  FULL_ROWS_M1 = DIM_WIDTH'(TILE_ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] CHUNK_STEP   = ADDR_WIDTH'(BUS_WIDTH_BYTES);

    walk_state_e             state_q, state_d;
    logic                    load, step, zero_dim;
    walk_mode_e              mode_q, mode_eff;
    logic [DIM_WIDTH-1:0]    chunks_m1_q, bands_m1_q, last_rows_m1_q;
    logic [DIM_WIDTH-1:0]    chunks_m1_n, bands_m1_n, last_rows_m1_n;
    logic [DIM_WIDTH-1:0]    chunks_m1_eff, bands_m1_eff, last_rows_m1_eff;
    logic [REPEAT_WIDTH-1:0] repeat_q, repeat_eff;
    logic [ADDR_WIDTH-1:0]   base_q, pitch_q, inner_step_q, outer_step_q, band_step_n;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, tile_base_q, tile_base_d, outer_base_q, outer_base_d;
    logic [ADDR_WIDTH-1:0]   tile_next, outer_next;
    logic                    row_last, inner_last, outer_last, walk_last;
    logic                    valid_q, busy_q, done_q;

    assign zero_dim       = (rows_i == '0) || (cols_i == '0);
    assign chunks_m1_n    = DIM_WIDTH'(ceil_div(32'(cols_i), ELEMENTS) - 32'd1);
    assign bands_m1_n     = DIM_WIDTH'(ceil_div(32'(rows_i), TILE_ROWS) - 32'd1);
    assign last_rows_m1_n = (rows_i - DIM_WIDTH'(1)) & FULL_ROWS_M1;
    assign band_step_n    = ADDR_WIDTH'(pitch_i) << TR_SHIFT;

    // The counter computes its next flags in the load cycle, so it sees the
    // incoming configuration directly rather than the not-yet-captured copy.
    assign mode_eff         = load ? walk_mode_e'(mode_i) : mode_q;
    assign chunks_m1_eff    = load ? chunks_m1_n : chunks_m1_q;
    assign bands_m1_eff     = load ? bands_m1_n : bands_m1_q;
    assign last_rows_m1_eff = load ? last_rows_m1_n : last_rows_m1_q;
    assign repeat_eff       = load ? repeat_i : repeat_q;

    // Walk control: next state plus load/step strobes; abort overrides all.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (zero_dim) begin
                        state_d = DONE;
                    end else begin
                        state_d = EMIT;
                        load    = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (addr_ready_i) begin
                    step = 1'b1;
                    if (walk_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            load    = 1'b0;
            step    = 1'b0;
        end
    end

    tile_walk_counter #(
        .DIM_WIDTH    (DIM_WIDTH),
        .REPEAT_WIDTH (REPEAT_WIDTH),
        .TILE_ROWS    (TILE_ROWS)
    ) u_counter (
        .clk            (clk),
        .reset          (reset),
        .load_i         (load),
        .step_i         (step),
        .mode_i         (mode_eff),
        .inner_max_i    ((mode_eff == CHUNK_MAJOR) ? bands_m1_eff : chunks_m1_eff),
        .outer_max_i    ((mode_eff == CHUNK_MAJOR) ? chunks_m1_eff : bands_m1_eff),
        .band_max_i     (bands_m1_eff),
        .last_rows_m1_i (last_rows_m1_eff),
        .repeat_i       (repeat_eff),
        .row_last_o     (row_last),
        .inner_last_o   (inner_last),
        .outer_last_o   (outer_last),
        .walk_last_o    (walk_last)
    );

    // Configuration capture at launch; inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q         <= BAND_MAJOR;
            chunks_m1_q    <= '0;
            bands_m1_q     <= '0;
            last_rows_m1_q <= '0;
            repeat_q       <= '0;
            base_q         <= '0;
            pitch_q        <= '0;
            inner_step_q   <= '0;
            outer_step_q   <= '0;
        end else if (load) begin
            mode_q         <= walk_mode_e'(mode_i);
            chunks_m1_q    <= chunks_m1_n;
            bands_m1_q     <= bands_m1_n;
            last_rows_m1_q <= last_rows_m1_n;
            repeat_q       <= repeat_i;
            base_q         <= base_addr_i;
            pitch_q        <= ADDR_WIDTH'(pitch_i);
            inner_step_q   <= mode_i ? band_step_n : CHUNK_STEP;
            outer_step_q   <= mode_i ? CHUNK_STEP : band_step_n;
        end
    end

    assign tile_next  = tile_base_q + inner_step_q;
    assign outer_next = outer_base_q + outer_step_q;

    // Address accumulators: row within tile, tile start, outer-loop start.
    always_comb begin
        addr_d       = addr_q;
        tile_base_d  = tile_base_q;
        outer_base_d = outer_base_q;
        if (load) begin
            addr_d       = base_addr_i;
            tile_base_d  = base_addr_i;
            outer_base_d = base_addr_i;
        end else if (step) begin
            if (!row_last) begin
                addr_d = addr_q + pitch_q;
            end else if (!inner_last) begin
                tile_base_d = tile_next;
                addr_d      = tile_next;
            end else if (!outer_last) begin
                outer_base_d = outer_next;
                tile_base_d  = outer_next;
                addr_d       = outer_next;
            end else begin
                outer_base_d = base_q;
                tile_base_d  = base_q;
                addr_d       = base_q;
            end
        end
    end

    // State, address and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            tile_base_q  <= '0;
            outer_base_q <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tile_base_q  <= tile_base_d;
            outer_base_q <= outer_base_d;
            valid_q      <= (state_d == EMIT);
            busy_q       <= (state_d != IDLE);
            done_q       <= (state_d == DONE);
        end
    end

    assign addr_o       = addr_q;
    assign addr_valid_o = valid_q;
    assign tile_last_o  = row_last;
    assign walk_last_o  = walk_last;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_tile_addr_walker.sv
// Self-checking bench for tile_addr_walker (default parameters).
module tb_tile_addr_walker;

    logic        clk = 1'b0;
    logic        reset, start_i, abort_i, mode_i, addr_ready_i;
    logic [15:0] rows_i, cols_i, pitch_i, base_addr_i, addr_o;
    logic [3:0]  repeat_i;
    logic        addr_valid_o, tile_last_o, walk_last_o, busy_o, done_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_addr[$];
    bit          exp_tl[$];
    bit          exp_wl[$];

    typedef struct {
        int          rows, cols, pitch, base, mode, rep, n;
        logic [191:0] addrs;   // first address in the top 16 bits
        logic [11:0]  tl;      // bit i = tile_last expected on address i
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    tile_addr_walker dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .mode_i       (mode_i),
        .rows_i       (rows_i),
        .cols_i       (cols_i),
        .pitch_i      (pitch_i),
        .base_addr_i  (base_addr_i),
        .repeat_i     (repeat_i),
        .addr_o       (addr_o),
        .addr_valid_o (addr_valid_o),
        .addr_ready_i (addr_ready_i),
        .tile_last_o  (tile_last_o),
        .walk_last_o  (walk_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: enumerate (pass, outer, inner, row) with plain arithmetic.
    task automatic model(input int rows, input int cols, input int pitch,
                         input int base, input int mode, input int rep);
        int bands, chunks, n_out, n_in, b, c, nr;
        bands  = (rows + 3) / 4;
        chunks = (cols + 31) / 32;
        n_out  = mode ? chunks : bands;
        n_in   = mode ? bands : chunks;
        exp_addr.delete();
        exp_tl.delete();
        exp_wl.delete();
        for (int p = 0; p <= rep; p++)
            for (int o = 0; o < n_out; o++)
                for (int i = 0; i < n_in; i++) begin
                    b  = mode ? i : o;
                    c  = mode ? o : i;
                    nr = rows - b * 4;
                    if (nr > 4) nr = 4;
                    for (int r = 0; r < nr; r++) begin
                        exp_addr.push_back(16'(base + (b * 4 + r) * pitch + c * 32));
                        exp_tl.push_back(r == nr - 1);
                        exp_wl.push_back(1'b0);
                    end
                end
        if (exp_wl.size() > 0) exp_wl[exp_wl.size() - 1] = 1'b1;
    endtask

    // Launch at one edge, then scramble the inputs to prove they were captured.
    task automatic start_walk(input int rows, input int cols, input int pitch,
                              input int base, input int mode, input int rep);
        @(negedge clk);
        rows_i      = 16'(rows);
        cols_i      = 16'(cols);
        pitch_i     = 16'(pitch);
        base_addr_i = 16'(base);
        mode_i      = 1'(mode);
        repeat_i    = 4'(rep);
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
        rows_i      = 16'($urandom);
        cols_i      = 16'($urandom);
        pitch_i     = 16'($urandom);
        base_addr_i = 16'($urandom);
        mode_i      = 1'($urandom_range(0, 1));
        repeat_i    = 4'($urandom);
    endtask

    // rmode: 0 = ready high, 1 = random ready, 2 = ready low 3 cycles on 2nd address.
    task automatic run_walk(input int rows, input int cols, input int pitch, input int base,
                            input int mode, input int rep, input int rmode, input string nm);
        int n, idx, cyc, stall, held;
        bit stalled, rdy;
        logic [15:0] ha;
        logic htl, hwl;
        n = exp_addr.size(); idx = 0; cyc = 0; stall = 0; held = 0;
        stalled = 1'b0; ha = '0; htl = 1'b0; hwl = 1'b0;
        start_walk(rows, cols, pitch, base, mode, rep);
        while (idx < n && cyc < 40 * n + 40) begin
            chk({nm, "/valid"}, 32'(addr_valid_o), 32'd1);
            rdy = 1'b0;
            if (addr_valid_o) begin
                if (stalled) begin
                    chk({nm, "/hold_addr"}, 32'(addr_o), 32'(ha));
                    chk({nm, "/hold_tile_last"}, 32'(tile_last_o), 32'(htl));
                    chk({nm, "/hold_walk_last"}, 32'(walk_last_o), 32'(hwl));
                end
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 1) != 0);
                    default: rdy = !(idx == 1 && stall < 3);
                endcase
                if (idx == 1) held++;
                if (rdy) begin
                    chk({nm, "/addr"}, 32'(addr_o), 32'(exp_addr[idx]));
                    chk({nm, "/tile_last"}, 32'(tile_last_o), 32'(exp_tl[idx]));
                    chk({nm, "/walk_last"}, 32'(walk_last_o), 32'(exp_wl[idx]));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stall++;
                    stalled = 1'b1;
                    ha  = addr_o;
                    htl = tile_last_o;
                    hwl = walk_last_o;
                end
            end
            addr_ready_i = rdy;
            start_i      = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            cyc++;
        end
        start_i      = 1'b0;
        addr_ready_i = 1'b0;
        chk({nm, "/handshakes"}, idx, n);
        chk({nm, "/done_pulse"}, 32'(done_o), 32'd1);
        chk({nm, "/valid_after_last"}, 32'(addr_valid_o), 32'd0);
        chk({nm, "/busy_in_done"}, 32'(busy_o), 32'd1);
        @(negedge clk);
        chk({nm, "/done_one_cycle"}, 32'(done_o), 32'd0);
        chk({nm, "/busy_idle"}, 32'(busy_o), 32'd0);
        chk({nm, "/valid_idle"}, 32'(addr_valid_o), 32'd0);
        if (rmode == 2) chk({nm, "/held_cycles"}, held, 4);
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 1'b0; addr_ready_i = 1'b0;
        rows_i = '0; cols_i = '0; pitch_i = '0; base_addr_i = '0; repeat_i = '0;

        tbl[0] = '{4, 32, 32, 'h100, 0, 0, 4,
                   {16'h100, 16'h120, 16'h140, 16'h160, 128'h0}, 12'h008};
        tbl[1] = '{6, 64, 64, 0, 0, 0, 12,
                   {16'd0, 16'd64, 16'd128, 16'd192, 16'd32, 16'd96,
                    16'd160, 16'd224, 16'd256, 16'd320, 16'd288, 16'd352}, 12'hA88};
        tbl[2] = '{6, 64, 64, 0, 1, 0, 12,
                   {16'd0, 16'd64, 16'd128, 16'd192, 16'd256, 16'd320,
                    16'd32, 16'd96, 16'd160, 16'd224, 16'd288, 16'd352}, 12'hA28};
        tbl[3] = '{2, 32, 32, 'hFFE0, 0, 1, 4,
                   {16'hFFE0, 16'h0000, 16'hFFE0, 16'h0000, 128'h0}, 12'h00A};

        repeat (3) @(negedge clk);
        chk("reset/addr", 32'(addr_o), 32'd0);
        chk("reset/valid", 32'(addr_valid_o), 32'd0);
        chk("reset/tile_last", 32'(tile_last_o), 32'd0);
        chk("reset/walk_last", 32'(walk_last_o), 32'd0);
        chk("reset/busy", 32'(busy_o), 32'd0);
        chk("reset/done", 32'(done_o), 32'd0);
        reset = 1'b0;

        // Directed vectors from the table.
        for (int k = 0; k < 4; k++) begin
            exp_addr.delete(); exp_tl.delete(); exp_wl.delete();
            for (int i = 0; i < tbl[k].n; i++) begin
                exp_addr.push_back(tbl[k].addrs[(11 - i) * 16 +: 16]);
                exp_tl.push_back(tbl[k].tl[i]);
                exp_wl.push_back(i == tbl[k].n - 1);
            end
            run_walk(tbl[k].rows, tbl[k].cols, tbl[k].pitch, tbl[k].base,
                     tbl[k].mode, tbl[k].rep, 0, $sformatf("vec%0d", k));
        end

        // Backpressure on the second address of the basic walk.
        model(4, 32, 32, 'h100, 0, 0);
        run_walk(4, 32, 32, 'h100, 0, 0, 2, "stall");

        // Zero dimension: done next cycle, never valid.
        for (int z = 0; z < 2; z++) begin
            start_walk(z == 0 ? 4 : 0, z == 0 ? 0 : 32, 32, 0, 0, 0);
            chk("zero/done", 32'(done_o), 32'd1);
            chk("zero/valid", 32'(addr_valid_o), 32'd0);
            chk("zero/busy", 32'(busy_o), 32'd1);
            @(negedge clk);
            chk("zero/done_clear", 32'(done_o), 32'd0);
            chk("zero/valid_idle", 32'(addr_valid_o), 32'd0);
            chk("zero/busy_idle", 32'(busy_o), 32'd0);
        end

        // Abort while the third address is on the bus.
        model(6, 64, 64, 0, 0, 0);
        start_walk(6, 64, 64, 0, 0, 0);
        addr_ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("abort/pre_addr", 32'(addr_o), 32'(exp_addr[i]));
            @(negedge clk);
        end
        chk("abort/third_valid", 32'(addr_valid_o), 32'd1);
        chk("abort/third_addr", 32'(addr_o), 32'(exp_addr[2]));
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        addr_ready_i = 1'b0;
        chk("abort/valid", 32'(addr_valid_o), 32'd0);
        chk("abort/busy", 32'(busy_o), 32'd0);
        chk("abort/done", 32'(done_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort/no_done", 32'(done_o), 32'd0);
            chk("abort/stay_idle", 32'(addr_valid_o), 32'd0);
        end

        // Randomized walks against the reference model.
        for (int t = 0; t < 25; t++) begin
            int rr, cc, pp, bb, mm, rp, rm;
            rr = $urandom_range(1, 11);
            cc = $urandom_range(1, 130);
            pp = $urandom_range(0, 65535);
            bb = $urandom_range(0, 65535);
            mm = $urandom_range(0, 1);
            rp = $urandom_range(0, 2);
            rm = $urandom_range(0, 1);
            model(rr, cc, pp, bb, mm, rp);
            run_walk(rr, cc, pp, bb, mm, rp, rm, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
